// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and constants for the VRAM port arbiter.
// Holds the ownership state enum, the read-return tag carried through the
// read-latency delay line, bus widths, and a small one-hot helper.
package vram_arb_pkg;

   localparam int unsigned VRAM_WORDS = 600;
   localparam int unsigned ADDR_W     = 11;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned BE_W       = 4;
   localparam int unsigned NREQ       = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   // Convert a requester id into its one-hot request/grant bit position
   function automatic logic [NREQ-1:0] id_to_onehot(input logic id);
      logic [NREQ-1:0] oh;
      if (id) begin
         oh = 2'b10;
      end else begin
         oh = 2'b01;
      end
      return oh;
   endfunction

endpackage

// File: rtl/vram_port_arb_if.sv
// vram_port_arb_if: requester handshake and BRAM port A signals of the
// VRAM arbiter. The slave modport is the arbiter's view; the master modport
// is the view of the environment (requesters plus the BRAM read data).
interface vram_port_arb_if;
   import vram_arb_pkg::*;

   logic [NREQ-1:0]   rq_req;
   logic [NREQ-1:0]   rq_lock;
   logic [BE_W-1:0]   rq_we0;
   logic [BE_W-1:0]   rq_we1;
   logic [ADDR_W-1:0] rq_addr0;
   logic [ADDR_W-1:0] rq_addr1;
   logic [DATA_W-1:0] rq_wdata0;
   logic [DATA_W-1:0] rq_wdata1;
   logic [NREQ-1:0]   rq_gnt;
   logic [NREQ-1:0]   rq_rvalid;
   logic [DATA_W-1:0] rq_rdata;
   logic [NREQ-1:0]   rq_err;
   logic [ADDR_W-1:0] bram_addr;
   logic [BE_W-1:0]   bram_we;
   logic [DATA_W-1:0] bram_din;
   logic [DATA_W-1:0] bram_dout;

   modport slave (
      input  rq_req, rq_lock, rq_we0, rq_we1, rq_addr0, rq_addr1,
             rq_wdata0, rq_wdata1, bram_dout,
      output rq_gnt, rq_rvalid, rq_rdata, rq_err,
             bram_addr, bram_we, bram_din
   );

   modport master (
      output rq_req, rq_lock, rq_we0, rq_we1, rq_addr0, rq_addr1,
             rq_wdata0, rq_wdata1, bram_dout,
      input  rq_gnt, rq_rvalid, rq_rdata, rq_err,
             bram_addr, bram_we, bram_din
   );

endinterface

// File: rtl/vram_rd_tag_pipe.sv
// vram_rd_tag_pipe: RD_LAT-deep delay line for read-return tags, aligned
// with the BRAM read latency. A tag entering with a granted read leaves
// exactly RD_LAT cycles later, when the BRAM output holds its data. The
// blank bit travels alongside and marks reads whose data must return zero.
module vram_rd_tag_pipe
   import vram_arb_pkg::*;
#(
   parameter int unsigned RD_LAT = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  rd_tag_t in_tag,
   input  logic    in_blank,
   output rd_tag_t out_tag,
   output logic    out_blank
);

   rd_tag_t           tag_q [RD_LAT];
   rd_tag_t           tag_d [RD_LAT];
   logic [RD_LAT-1:0] blank_q;
   logic [RD_LAT-1:0] blank_d;

   // Shift every stage one step toward the output; stage 0 takes the new tag
   always_comb begin
      tag_d[0]   = in_tag;
      blank_d    = blank_q;
      blank_d[0] = in_blank;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         tag_d[i]   = tag_q[i-1];
         blank_d[i] = blank_q[i-1];
      end
   end

   // Stage registers; reset invalidates every in-flight tag
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            tag_q[i] <= '0;
         end
         blank_q <= '0;
      end else begin
         tag_q   <= tag_d;
         blank_q <= blank_d;
      end
   end

   assign out_tag   = tag_q[RD_LAT-1];
   assign out_blank = blank_q[RD_LAT-1];

endmodule

// File: rtl/vram_port_arb.sv
// vram_port_arb: arbitrates BRAM port A between requester 0 (AXI side) and
// requester 1 (hardware engine). Grants are combinational from the ownership
// state and the live requests so an accepted access drives the BRAM in the
// same cycle. A requester may keep ownership across grants with rq_lock.
// Accesses at or above CTRL_ADDR are granted but never write the BRAM; they
// flag rq_err one cycle later and reads of them return zero.
// Build option: define VRAM_ARB_RR_EN for round-robin arbitration in IDLE;
// when undefined requester 0 always wins and no pointer register exists.
module vram_port_arb
   import vram_arb_pkg::*;
#(
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned CTRL_ADDR = VRAM_WORDS
) (
   input  logic           clk,
   input  logic           reset,
   vram_port_arb_if.slave bus
);

   arb_state_t        state_q, state_d;
   logic [NREQ-1:0]   idle_gnt_s;
   logic [NREQ-1:0]   gnt_s;
   logic              gnt_any_s;
   logic              sel_id_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [BE_W-1:0]   sel_we_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              ctrl_hit_s;
   logic              rd_start_s;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [BE_W-1:0]   we_s;
   logic [NREQ-1:0]   err_q, err_d;
   rd_tag_t           tag_in_s;
   rd_tag_t           tag_out_s;
   logic              blank_out_s;
   logic [NREQ-1:0]   rvalid_s;
   logic [DATA_W-1:0] rdata_s;

`ifdef VRAM_ARB_RR_EN
   logic ptr_q, ptr_d;

   // IDLE winner: on a tie the requester favoured by the pointer wins
   always_comb begin
      if (bus.rq_req == 2'b11) begin
         idle_gnt_s = id_to_onehot(ptr_q);
      end else begin
         idle_gnt_s = bus.rq_req;
      end
   end

   // Pointer favours the requester that was not granted last
   always_comb begin
      if (gnt_any_s) begin
         ptr_d = ~sel_id_s;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register, favouring requester 0 out of reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   // IDLE winner: requester 0 has fixed priority
   always_comb begin
      if (bus.rq_req[0]) begin
         idle_gnt_s = 2'b01;
      end else if (bus.rq_req[1]) begin
         idle_gnt_s = 2'b10;
      end else begin
         idle_gnt_s = 2'b00;
      end
   end
`endif

   // Ownership FSM next state and grant; no grant while reset is asserted
   always_comb begin
      gnt_s   = 2'b00;
      state_d = state_q;
      if (reset) begin
         gnt_s   = 2'b00;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               gnt_s = idle_gnt_s;
               if (idle_gnt_s[0] && bus.rq_lock[0]) begin
                  state_d = OWN0;
               end else if (idle_gnt_s[1] && bus.rq_lock[1]) begin
                  state_d = OWN1;
               end else begin
                  state_d = IDLE;
               end
            end
            OWN0: begin
               gnt_s = {1'b0, bus.rq_req[0]};
               if (!bus.rq_lock[0] || !bus.rq_req[0]) begin
                  state_d = IDLE;
               end else begin
                  state_d = OWN0;
               end
            end
            OWN1: begin
               gnt_s = {bus.rq_req[1], 1'b0};
               if (!bus.rq_lock[1] || !bus.rq_req[1]) begin
                  state_d = IDLE;
               end else begin
                  state_d = OWN1;
               end
            end
            default: begin
               gnt_s   = 2'b00;
               state_d = IDLE;
            end
         endcase
      end
   end

   assign gnt_any_s = |gnt_s;
   assign sel_id_s  = gnt_s[1];

   // Select the granted requester's transaction fields
   always_comb begin
      if (sel_id_s) begin
         sel_addr_s  = bus.rq_addr1;
         sel_we_s    = bus.rq_we1;
         sel_wdata_s = bus.rq_wdata1;
      end else begin
         sel_addr_s  = bus.rq_addr0;
         sel_we_s    = bus.rq_we0;
         sel_wdata_s = bus.rq_wdata0;
      end
   end

   assign ctrl_hit_s = (32'(sel_addr_s) >= CTRL_ADDR);
   assign rd_start_s = gnt_any_s && (sel_we_s == 4'b0000);

   // BRAM port drive: follow the grant, otherwise hold address/data, never write
   always_comb begin
      if (gnt_any_s) begin
         addr_d = sel_addr_s;
         din_d  = sel_wdata_s;
      end else begin
         addr_d = addr_q;
         din_d  = din_q;
      end
      if (gnt_any_s && !ctrl_hit_s) begin
         we_s = sel_we_s;
      end else begin
         we_s = 4'b0000;
      end
   end

   // Error flag for the granted requester when it touched the control word
   always_comb begin
      if (gnt_any_s && ctrl_hit_s) begin
         err_d = gnt_s;
      end else begin
         err_d = 2'b00;
      end
   end

   // State, held BRAM address/data and error pulse registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         din_q   <= '0;
         err_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         err_q   <= err_d;
      end
   end

   // Tag for a granted read: which requester gets the data back
   always_comb begin
      tag_in_s.valid = rd_start_s;
      tag_in_s.id    = sel_id_s;
   end

   vram_rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_tag    (tag_in_s),
      .in_blank  (ctrl_hit_s),
      .out_tag   (tag_out_s),
      .out_blank (blank_out_s)
   );

   // Read return: pulse rvalid for the tagged requester; data is zero otherwise
   always_comb begin
      rvalid_s = 2'b00;
      rdata_s  = 32'h0000_0000;
      if (tag_out_s.valid) begin
         rvalid_s = id_to_onehot(tag_out_s.id);
         if (blank_out_s) begin
            rdata_s = 32'h0000_0000;
         end else begin
            rdata_s = bus.bram_dout;
         end
      end else begin
         rvalid_s = 2'b00;
         rdata_s  = 32'h0000_0000;
      end
   end

   assign bus.rq_gnt    = gnt_s;
   assign bus.rq_err    = err_q;
   assign bus.rq_rvalid = rvalid_s;
   assign bus.rq_rdata  = rdata_s;
   assign bus.bram_addr = addr_d;
   assign bus.bram_din  = din_d;
   assign bus.bram_we   = we_s;

endmodule

// File: doc/vram_port_arb.md
VRAM_PORT_ARB -- requirements
Module: vram_port_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter RD_LAT, default 2, SHALL be the BRAM read latency in cycles (legal 1..4).
REQ-003 Parameter CTRL_ADDR, default 600, SHALL be the control-register word address, which is excluded from VRAM.
REQ-004 Ports SHALL be:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rq_req[1:0]  in  2  per-requester request
- rq_lock[1:0]  in  2  keep ownership after the current grant
- rq_we0/rq_we1  in  4 each  byte write enables; 0 means read
- rq_addr0/rq_addr1  in  11 each  word address
- rq_wdata0/rq_wdata1  in  32 each  write data
- rq_gnt[1:0]  out  2  one-hot grant; the transaction is accepted this cycle
- rq_rvalid[1:0]  out  2  read data valid, per requester
- rq_rdata  out  32  read data, shared
- rq_err[1:0]  out  2  access to an address >= CTRL_ADDR was rejected
- bram_addr  out  11  BRAM port A address
- bram_we  out  4  BRAM port A byte write enables
- bram_din  out  32  BRAM port A write data
- bram_dout  in  32  BRAM port A read data

Function
REQ-005 Requester 0 is the AXI side and requester 1 is the hardware engine; at most one rq_gnt bit SHALL be high per cycle.
REQ-006 Grant SHALL be combinational from the registered state and the current rq_req; an accepted transaction SHALL drive the bram_* ports in the same cycle.
REQ-007 The state machine SHALL have the states IDLE, OWN0 and OWN1.
- IDLE: grant per the arbitration policy (REQ-017). Go to OWNn if the granted requester has rq_lock[n]=1, else stay in IDLE.
- OWNn: only requester n may be granted. Return to IDLE when rq_lock[n]=0 or rq_req[n]=0.
REQ-008 With no grant, bram_we SHALL be 0 and bram_addr/bram_din SHALL hold their last values.
REQ-009 For a granted read, a tag {valid,id} SHALL enter a pipeline RD_LAT deep. When the tag exits, rq_rvalid[id] SHALL pulse for 1 cycle with rq_rdata=bram_dout.
REQ-010 Reads SHALL be fully pipelined: one read per cycle is allowed, and the returned data SHALL stay in grant order.
REQ-011 A granted write SHALL produce no rvalid.
REQ-012 An access with addr >= CTRL_ADDR SHALL still be granted, with bram_we forced to 0. It SHALL pulse rq_err[id] 1 cycle after the grant. A read of such an address SHALL return rq_rdata=0 with rvalid at the normal latency.
REQ-013 If both requesters request in the same cycle, the loser SHALL see rq_gnt=0 and SHALL hold its request; no request SHALL be dropped.
REQ-014 rq_rdata SHALL be 0 in every cycle without an rvalid.

Reset
REQ-015 Reset SHALL set: state to IDLE, the tag pipeline to invalid, rq_rvalid=0, rq_err=0, bram_we=0, bram_addr=0, bram_din=0, and the round-robin pointer to favour requester 0.
REQ-016 Reset asserted mid-operation SHALL discard in-flight read tags: no rvalid SHALL follow reset, even if bram_dout changes.

Configuration
REQ-017 The macro VRAM_ARB_RR_EN SHALL select the arbitration policy.
- Defined: round-robin in IDLE. The pointer favours the requester not granted last and updates on every grant.
- Undefined: fixed priority, requester 0 always wins; no pointer register.

Structure
REQ-018 The package vram_arb_pkg SHALL hold the arb_state_t enum {IDLE,OWN0,OWN1}, the rd_tag_t struct {valid,id}, and the VRAM_WORDS=600 constant.
REQ-019 The tag delay line SHALL be a sub-module vram_rd_tag_pipe, parameterised by RD_LAT.

Verification
REQ-020 Scenario: req0 read of addr 5 (BRAM word 5=0xDEADBEEF), RD_LAT=2 -> gnt0 in cycle 0, rvalid0 in cycle 2 with rdata=0xDEADBEEF.
REQ-021 Scenario: req0 and req1 both held for 4 cycles, RR_EN defined -> grants 0,1,0,1. With RR_EN undefined -> grants 0,0,0,0.
REQ-022 Scenario: req1 with lock=1 for 3 writes while req0 is pending -> gnt1 for 3 cycles, gnt0 only after lock drops.
REQ-023 Scenario: req0 write we=4'b1111 to addr 600 -> gnt0, bram_we=0, rq_err[0] pulses at cycle 1, BRAM is unchanged.
REQ-024 Scenario: reads to addrs 1,2,3 back-to-back, then reset at cycle 1 -> rvalid never asserts and state is IDLE after reset.
REQ-025 Scenario: req0 reads addr 10 while req1 reads addr 11 in the next cycle -> rvalid0 at cycle 2 and rvalid1 at cycle 3, with the correct data each.
